// File: rtl/arm7tdmi_shift_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : arm7tdmi_shift_operand_stage
// Description : Operand-2 preparation stage placed in front of the barrel
//               shifter. Captures the decoded operand-2 fields and, for
//               register-specified shifts, fetches Rs with an extra cycle.
//               Every encoding is reduced to 5-bit shifter controls, plus an
//               override result for the cases the shifter cannot express
//               (#32 encodings, amounts >= 32, register amount 0).
// Options     : ARM7TDMI_RS_FWD_EN - adds fwd_en/fwd_addr/fwd_data so that a
//               forwarded Rs value replaces the register-file read data.
// Revision    : 1.0 - initial release
// ============================================================================
module arm7tdmi_shift_operand_stage #(
    parameter int RS_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_imm_op,
    input  logic [7:0]  in_imm8,
    input  logic [3:0]  in_rot,
    input  logic [31:0] in_rm_data,
    input  logic [1:0]  in_shift_type,
    input  logic [4:0]  in_shift_imm,
    input  logic        in_shift_reg,
    input  logic [3:0]  in_rs_addr,
    input  logic        in_carry,
    output logic        rs_rd_en,
    output logic [3:0]  rs_rd_addr,
    input  logic [31:0] rs_rd_data,
`ifdef ARM7TDMI_RS_FWD_EN
    input  logic        fwd_en,
    input  logic [3:0]  fwd_addr,
    input  logic [31:0] fwd_data,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sh_data,
    output logic [1:0]  sh_type,
    output logic [4:0]  sh_amount,
    output logic        sh_carry,
    output logic        ovr_en,
    output logic [31:0] ovr_data,
    output logic        ovr_carry,
    output logic        out_reg_shift
);

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    // Last RS_WAIT count value; the read data is valid in that cycle.
    localparam logic [1:0] WAIT_LAST = 2'(RS_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RS_REQ  = 2'd1,
        S_RS_WAIT = 2'd2,
        S_VALID   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  wait_cnt_q;
    logic        imm_op_q;
    logic [7:0]  imm8_q;
    logic [3:0]  rot_q;
    logic [31:0] rm_q;
    logic [1:0]  type_q;
    logic [4:0]  shift_imm_q;
    logic        shift_reg_q;
    logic [3:0]  rs_addr_q;
    logic        carry_q;
    logic [7:0]  rs_amt_q;

    logic        w_accept;
    logic        w_accept_reg;
    logic        w_rs_done;
    logic [7:0]  w_rs_byte;
    logic        w_unused;

    // Handshake: flush blocks acceptance; a held VALID frees only when drained.
    always_comb begin
        in_ready     = !rst && !flush &&
                       ((state_q == S_IDLE) || ((state_q == S_VALID) && out_ready));
        w_accept     = in_valid && in_ready;
        w_accept_reg = in_shift_reg && !in_imm_op;
        w_rs_done    = (state_q == S_RS_WAIT) && (wait_cnt_q == WAIT_LAST);
    end

    // Rs amount source: forwarded value wins over the register-file read.
`ifdef ARM7TDMI_RS_FWD_EN
    always_comb begin
        w_rs_byte = rs_rd_data[7:0];
        if (fwd_en && (fwd_addr == rs_addr_q)) begin
            w_rs_byte = fwd_data[7:0];
        end
    end
    assign w_unused = ^{rs_rd_data[31:8], fwd_data[31:8]};
`else
    assign w_rs_byte = rs_rd_data[7:0];
    assign w_unused  = ^rs_rd_data[31:8];
`endif

    // Next-state selection; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = w_accept_reg ? S_RS_REQ : S_VALID;
                end
            end
            S_RS_REQ: begin
                state_d = S_RS_WAIT;
            end
            S_RS_WAIT: begin
                if (w_rs_done) begin
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (out_ready) begin
                    if (w_accept) begin
                        state_d = w_accept_reg ? S_RS_REQ : S_VALID;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State register, op capture at accept and Rs capture at end of wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 2'd0;
            imm_op_q    <= 1'b0;
            imm8_q      <= 8'd0;
            rot_q       <= 4'd0;
            rm_q        <= 32'd0;
            type_q      <= 2'd0;
            shift_imm_q <= 5'd0;
            shift_reg_q <= 1'b0;
            rs_addr_q   <= 4'd0;
            carry_q     <= 1'b0;
            rs_amt_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_RS_REQ) begin
                wait_cnt_q <= 2'd0;
            end else if (state_q == S_RS_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 2'd1;
            end
            if (w_rs_done && !flush) begin
                rs_amt_q <= w_rs_byte;
            end
            if (w_accept) begin
                imm_op_q    <= in_imm_op;
                imm8_q      <= in_imm8;
                rot_q       <= in_rot;
                rm_q        <= in_rm_data;
                type_q      <= in_shift_type;
                shift_imm_q <= in_shift_imm;
                shift_reg_q <= w_accept_reg;
                rs_addr_q   <= in_rs_addr;
                carry_q     <= in_carry;
            end
        end
    end

    assign out_valid     = (state_q == S_VALID);
    assign rs_rd_en      = (state_q == S_RS_REQ);
    assign rs_rd_addr    = rs_addr_q;
    assign out_reg_shift = shift_reg_q;

    // Normalise the captured op into shifter controls plus the override path.
    always_comb begin
        sh_data   = rm_q;
        sh_type   = type_q;
        sh_amount = shift_imm_q;
        sh_carry  = carry_q;
        ovr_en    = 1'b0;
        ovr_data  = 32'd0;
        ovr_carry = 1'b0;
        if (imm_op_q) begin
            sh_data   = {24'd0, imm8_q};
            sh_type   = SH_ROR;
            sh_amount = {rot_q, 1'b0};
            if (rot_q == 4'd0) begin
                ovr_en    = 1'b1;
                ovr_data  = {24'd0, imm8_q};
                ovr_carry = carry_q;
            end
        end else if (shift_reg_q) begin
            sh_amount = rs_amt_q[4:0];
            if (rs_amt_q == 8'd0) begin
                // Zero register amount passes Rm and C untouched (never RRX).
                ovr_en    = 1'b1;
                ovr_data  = rm_q;
                ovr_carry = carry_q;
            end else begin
                unique case (type_q)
                    SH_LSL: begin
                        if (rs_amt_q == 8'd32) begin
                            ovr_en    = 1'b1;
                            ovr_carry = rm_q[0];
                        end else if (rs_amt_q > 8'd32) begin
                            ovr_en    = 1'b1;
                        end
                    end
                    SH_LSR: begin
                        if (rs_amt_q == 8'd32) begin
                            ovr_en    = 1'b1;
                            ovr_carry = rm_q[31];
                        end else if (rs_amt_q > 8'd32) begin
                            ovr_en    = 1'b1;
                        end
                    end
                    SH_ASR: begin
                        if (rs_amt_q >= 8'd32) begin
                            ovr_en    = 1'b1;
                            ovr_data  = {32{rm_q[31]}};
                            ovr_carry = rm_q[31];
                        end
                    end
                    SH_ROR: begin
                        if (rs_amt_q[4:0] == 5'd0) begin
                            ovr_en    = 1'b1;
                            ovr_data  = rm_q;
                            ovr_carry = rm_q[31];
                        end
                    end
                endcase
            end
        end else if (shift_imm_q == 5'd0) begin
            // Immediate #0 encodings meaning #32 for LSR/ASR; LSL#0 and RRX go to the shifter.
            if (type_q == SH_LSR) begin
                ovr_en    = 1'b1;
                ovr_carry = rm_q[31];
            end else if (type_q == SH_ASR) begin
                ovr_en    = 1'b1;
                ovr_data  = {32{rm_q[31]}};
                ovr_carry = rm_q[31];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm7tdmi_shift_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_arm7tdmi_shift_operand_stage
// Description : Directed self-checking bench for the operand-2 stage with a
//               two-cycle register-file read model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm7tdmi_shift_operand_stage;

    localparam int RS_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_imm_op = 1'b0;
    logic [7:0]  in_imm8 = 8'd0;
    logic [3:0]  in_rot = 4'd0;
    logic [31:0] in_rm_data = 32'd0;
    logic [1:0]  in_shift_type = 2'd0;
    logic [4:0]  in_shift_imm = 5'd0;
    logic        in_shift_reg = 1'b0;
    logic [3:0]  in_rs_addr = 4'd0;
    logic        in_carry = 1'b0;
    logic        rs_rd_en;
    logic [3:0]  rs_rd_addr;
    logic [31:0] rs_rd_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sh_data;
    logic [1:0]  sh_type;
    logic [4:0]  sh_amount;
    logic        sh_carry;
    logic        ovr_en;
    logic [31:0] ovr_data;
    logic        ovr_carry;
    logic        out_reg_shift;
`ifdef ARM7TDMI_RS_FWD_EN
    logic        fwd_en = 1'b0;
    logic [3:0]  fwd_addr = 4'd0;
    logic [31:0] fwd_data = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [16];
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;

    always #5 clk = ~clk;

    arm7tdmi_shift_operand_stage #(.RS_LAT(RS_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_imm_op     (in_imm_op),
        .in_imm8       (in_imm8),
        .in_rot        (in_rot),
        .in_rm_data    (in_rm_data),
        .in_shift_type (in_shift_type),
        .in_shift_imm  (in_shift_imm),
        .in_shift_reg  (in_shift_reg),
        .in_rs_addr    (in_rs_addr),
        .in_carry      (in_carry),
        .rs_rd_en      (rs_rd_en),
        .rs_rd_addr    (rs_rd_addr),
        .rs_rd_data    (rs_rd_data),
`ifdef ARM7TDMI_RS_FWD_EN
        .fwd_en        (fwd_en),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sh_data       (sh_data),
        .sh_type       (sh_type),
        .sh_amount     (sh_amount),
        .sh_carry      (sh_carry),
        .ovr_en        (ovr_en),
        .ovr_data      (ovr_data),
        .ovr_carry     (ovr_carry),
        .out_reg_shift (out_reg_shift)
    );

    // Register file with two-cycle read latency; garbage when no read is pending.
    always @(posedge clk) begin
        d1 <= rs_rd_en ? rf[rs_rd_addr] : 32'h0000_00A5;
        d2 <= d1;
    end
    assign rs_rd_data = d2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic imm, input logic [7:0] i8, input logic [3:0] rot,
                         input logic [31:0] rm, input logic [1:0] ty, input logic [4:0] si,
                         input logic sr, input logic [3:0] rs, input logic c);
        in_imm_op     = imm;
        in_imm8       = i8;
        in_rot        = rot;
        in_rm_data    = rm;
        in_shift_type = ty;
        in_shift_imm  = si;
        in_shift_reg  = sr;
        in_rs_addr    = rs;
        in_carry      = c;
        in_valid      = 1'b1;
        #1;
        chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Register-shift op: checks the read request and the 2+RS_LAT latency.
    task automatic do_reg(input logic [1:0] ty, input logic [31:0] rm, input logic c,
                          input logic [3:0] rs);
        int n;
        issue(1'b0, 8'd0, 4'd0, rm, ty, 5'd0, 1'b1, rs, c);
        chk("rs_rd_en_cycle1", {31'd0, rs_rd_en}, 32'd1);
        chk("rs_rd_addr", {28'd0, rs_rd_addr}, {28'd0, rs});
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("reg_latency", n, 32'd3);
        chk("out_reg_shift", {31'd0, out_reg_shift}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (rf[i]) rf[i] = 32'd0;
        rf[3] = 32'h20;
        rf[4] = 32'h40;
        rf[5] = 32'h100;
        rf[6] = 32'h5;
        rf[7] = 32'h20;
        rf[8] = 32'h10;

        // Reset values
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready_held", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ovr_en", {31'd0, ovr_en}, 32'd0);
        chk("rst_sh_data", sh_data, 32'd0);
        chk("rst_rs_rd_en", {31'd0, rs_rd_en}, 32'd0);

        // Rotated immediate 0xFF ror 8
        issue(1'b1, 8'hFF, 4'd4, 32'd0, 2'd0, 5'd0, 1'b0, 4'd0, 1'b0);
        chk("imm_out_valid", {31'd0, out_valid}, 32'd1);
        chk("imm_sh_type", {30'd0, sh_type}, 32'd3);
        chk("imm_sh_amount", {27'd0, sh_amount}, 32'd8);
        chk("imm_ovr_en", {31'd0, ovr_en}, 32'd0);
        chk("imm_sh_data", sh_data, 32'h0000_00FF);
        chk("imm_reg_shift", {31'd0, out_reg_shift}, 32'd0);

        // Unrotated immediate keeps C
        issue(1'b1, 8'hFF, 4'd0, 32'd0, 2'd0, 5'd0, 1'b0, 4'd0, 1'b1);
        chk("imm0_ovr_en", {31'd0, ovr_en}, 32'd1);
        chk("imm0_ovr_data", ovr_data, 32'h0000_00FF);
        chk("imm0_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        // LSR#0 means LSR#32
        issue(1'b0, 8'd0, 4'd0, 32'h8000_0001, 2'd1, 5'd0, 1'b0, 4'd0, 1'b0);
        chk("lsr0_ovr_en", {31'd0, ovr_en}, 32'd1);
        chk("lsr0_ovr_data", ovr_data, 32'd0);
        chk("lsr0_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        // ASR#0 means ASR#32
        issue(1'b0, 8'd0, 4'd0, 32'h8000_0001, 2'd2, 5'd0, 1'b0, 4'd0, 1'b0);
        chk("asr0_ovr_data", ovr_data, 32'hFFFF_FFFF);
        chk("asr0_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        // ROR#0 is RRX and goes to the shifter
        issue(1'b0, 8'd0, 4'd0, 32'h8000_0001, 2'd3, 5'd0, 1'b0, 4'd0, 1'b1);
        chk("rrx_ovr_en", {31'd0, ovr_en}, 32'd0);
        chk("rrx_sh_amount", {27'd0, sh_amount}, 32'd0);
        chk("rrx_sh_type", {30'd0, sh_type}, 32'd3);
        chk("rrx_sh_carry", {31'd0, sh_carry}, 32'd1);

        // Register shifts
        tick();
        do_reg(2'd0, 32'h1, 1'b0, 4'd3);
        chk("lsl32_ovr_en", {31'd0, ovr_en}, 32'd1);
        chk("lsl32_ovr_data", ovr_data, 32'd0);
        chk("lsl32_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        do_reg(2'd3, 32'h8000_0000, 1'b0, 4'd4);
        chk("ror64_ovr_data", ovr_data, 32'h8000_0000);
        chk("ror64_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        do_reg(2'd1, 32'h1234_5678, 1'b1, 4'd5);
        chk("lsr256_ovr_en", {31'd0, ovr_en}, 32'd1);
        chk("lsr256_ovr_data", ovr_data, 32'h1234_5678);
        chk("lsr256_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        do_reg(2'd0, 32'h1, 1'b0, 4'd6);
        chk("lsl5_ovr_en", {31'd0, ovr_en}, 32'd0);
        chk("lsl5_sh_amount", {27'd0, sh_amount}, 32'd5);
        chk("lsl5_sh_data", sh_data, 32'h1);

        do_reg(2'd1, 32'h8000_0000, 1'b0, 4'd7);
        chk("lsr32_ovr_data", ovr_data, 32'd0);
        chk("lsr32_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        do_reg(2'd2, 32'h8000_0000, 1'b0, 4'd4);
        chk("asr64_ovr_data", ovr_data, 32'hFFFF_FFFF);
        chk("asr64_ovr_carry", {31'd0, ovr_carry}, 32'd1);

        // Backpressure holds outputs
        tick();
        out_ready = 1'b0;
        issue(1'b1, 8'h81, 4'd2, 32'd0, 2'd0, 5'd0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sh_amount", {27'd0, sh_amount}, 32'd4);
            chk("bp_sh_data", sh_data, 32'h0000_0081);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush beats in_valid
        out_ready = 1'b0;
        issue(1'b1, 8'h11, 4'd0, 32'd0, 2'd0, 5'd0, 1'b0, 4'd0, 1'b0);
        chk("fl_pre_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("fl_no_accept", {31'd0, out_valid}, 32'd0);

        // Flush during an Rs fetch
        issue(1'b0, 8'd0, 4'd0, 32'h1, 2'd0, 5'd0, 1'b1, 4'd3, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flrs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        repeat (4) tick();
        chk("flrs_out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset during an Rs fetch
        issue(1'b0, 8'd0, 4'd0, 32'h1, 2'd0, 5'd0, 1'b1, 4'd3, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        chk("arst_reg_shift", {31'd0, out_reg_shift}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) tick();
        chk("arst_no_valid", {31'd0, out_valid}, 32'd0);

`ifdef ARM7TDMI_RS_FWD_EN
        // Forwarded Rs replaces the register-file data
        fwd_en   = 1'b1;
        fwd_addr = 4'd8;
        fwd_data = 32'h3;
        do_reg(2'd0, 32'h1, 1'b0, 4'd8);
        chk("fwd_sh_amount", {27'd0, sh_amount}, 32'd3);
        chk("fwd_ovr_en", {31'd0, ovr_en}, 32'd0);
        fwd_en = 1'b0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
